fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Instruction fetch front end feeding pipelineID: owns the fetch PC, issues
//   in-order requests to instruction memory, buffers returned words with
//   their PCs in a DEPTH-entry FIFO, presents them to ID under valid/ready.
//   Replaces the fixed-latency fetch path in pipelineIF. Supports branch/jump
//   redirect from EXE with flush of queued and in-flight fetches.
// PARAMETERS
//   DEPTH     4             FIFO entries, power of two, >=2
//   RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//   clk            in   1   clock; all state updates on rising edge
//   reset          in   1   synchronous reset, active-high
//   redirectValid  in   1   EXE redirect strobe (taken branch/jump)
//   redirectPc     in   32  redirect target; bits[1:0] forced to 0
//   imemReqValid   out  1   fetch request valid
//   imemReqReady   in   1   imem accepts request this cycle
//   imemReqAddr    out  32  fetch address (= fetchPc)
//   imemRespValid  in   1   response word valid (in order, >=1 cycle after accept)
//   imemRespData   in   32  response instruction word
//   instrValidF    out  1   instruction available to ID
//   instrF         out  32  instruction to ID
//   pcF            out  32  PC of instrF
//   instrReadyD    in   1   ID accepts instrF (low = ID stall)
// BEHAVIOUR
//   - Reset: fetchPc=respPc=RESET_PC, count=outstanding=dropCount=0;
//     imemReqValid=0, instrValidF=0, instrF=32'h0000_0013 (NOP), pcF=0.
//   - Credit rule: imemReqValid = !redirectValid && (count+outstanding < DEPTH);
//     FIFO can never overflow. Accept = imemReqValid && imemReqReady:
//     fetchPc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding++.
//   - Response: outstanding--. If dropCount!=0: word discarded, dropCount--.
//     Else push {respPc, imemRespData}, respPc += 4. Response with
//     outstanding==0 is ignored.
//   - Pop: instrValidF && instrReadyD removes head. Push and pop in same
//     cycle leave count unchanged. Empty: instrValidF=0, instrF=NOP, pcF=last.
//   - Redirect (priority over push, pop, accept in same cycle): FIFO cleared,
//     fetchPc=respPc={redirectPc[31:2],2'b00}, dropCount = outstanding minus
//     1 if a response arrives that cycle (that word also discarded). Next
//     request issues the cycle after redirect.
//   - Latency: imem response to instrValidF = 1 cycle (registered FIFO).
//   - Reset asserted mid-operation: all state returns to reset values next
//     edge; in-flight responses after reset are ignored (outstanding=0).
//   - imemReqAddr/Valid stable while imemReqValid && !imemReqReady, unless
//     redirect (request withdrawn).
// CONFIGURATION
//   FETCH_QUEUE_BYPASS_EN defined: when FIFO empty and an undropped response
//     arrives, it is presented combinationally on instrF/pcF with instrValidF=1
//     the same cycle; if instrReadyD it is not written into the FIFO.
//     Response-to-ID latency 0.
//   Not defined: no bypass; every word passes through the FIFO, latency 1.
// TESTING
//   1 Reset, imemReqReady=1, 1-cycle imem -> addrs 0,4,8.. issued; ID sees
//     pcF 0,4,8 in order, one per cycle after fill.
//   2 instrReadyD=0 for 10 cycles -> exactly DEPTH(4) requests accepted,
//     imemReqValid=0, count=4; release -> drains 4 then resumes.
//   3 2 requests in flight, redirectValid with redirectPc=32'h0000_0102 ->
//     FIFO empty, both late responses dropped, next addr 32'h0000_0100.
//   4 redirect same cycle as response and pop -> response dropped,
//     instrValidF=0 next cycle, no double pop.
//   5 redirectPc=32'hFFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   6 BYPASS_EN: empty queue, response 32'h0010_0093 with ready=1 ->
//     instrValidF=1, instrF=32'h0010_0093 same cycle; count stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction fetch front end. Owns the fetch PC, issues in-order
//            requests to instruction memory, buffers returned words with
//            their PCs in a DEPTH-entry FIFO and hands them to ID under
//            valid/ready. A redirect from EXE flushes queued words and marks
//            in-flight fetches for discard.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
// Ports
//   clk            in   1   clock, rising edge
//   reset          in   1   synchronous reset, active-high
//   redirectValid  in   1   EXE redirect strobe
//   redirectPc     in   32  redirect target (bits [1:0] ignored)
//   imemReqValid   out  1   fetch request valid
//   imemReqReady   in   1   imem accepts request
//   imemReqAddr    out  32  fetch address
//   imemRespValid  in   1   response word valid (in order)
//   imemRespData   in   32  response instruction word
//   instrValidF    out  1   instruction available to ID
//   instrF         out  32  instruction to ID (NOP when empty)
//   pcF            out  32  PC of instrF (last delivered PC when empty)
//   instrReadyD    in   1   ID accepts instrF
// Configuration
//   FETCH_QUEUE_BYPASS_EN  when defined, an undropped response arriving at an
//                          empty queue is forwarded to ID in the same cycle.
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirectValid,
  input  logic [31:0] redirectPc,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        instrValidF,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  input  logic        instrReadyD
);

  localparam int          C_AW    = $clog2(DEPTH);
  localparam int          C_CW    = C_AW + 1;
  localparam logic [31:0] C_NOP   = 32'h0000_0013;
  localparam logic [C_CW:0] C_DEPTH = (C_CW + 1)'(DEPTH);

  logic [31:0]     r_fetchPc;
  logic [31:0]     r_respPc;
  logic [31:0]     r_lastPc;
  logic [C_CW-1:0] r_count;
  logic [C_CW-1:0] r_outstanding;
  logic [C_CW-1:0] r_dropCount;
  logic [C_AW-1:0] r_wrPtr;
  logic [C_AW-1:0] r_rdPtr;
  logic [31:0]     r_instrMem [DEPTH];
  logic [31:0]     r_pcMem    [DEPTH];

  logic [C_CW:0]   w_inUse;
  logic            w_empty;
  logic            w_accept;
  logic            w_respAcc;
  logic            w_respKeep;
  logic            w_bypass;
  logic            w_pop;
  logic            w_fifoPop;
  logic            w_push;
  logic [31:0]     w_redirTarget;

  // Credit check covers both buffered words and words still in flight, so a
  // returning response always has a free FIFO slot.
  assign w_inUse      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_empty      = (r_count == '0);
  assign imemReqValid = !reset && !redirectValid && (w_inUse < C_DEPTH);
  assign imemReqAddr  = r_fetchPc;
  assign w_accept     = imemReqValid && imemReqReady;

  // Responses with nothing outstanding are stray (e.g. issued before reset).
  assign w_respAcc     = imemRespValid && (r_outstanding != '0);
  assign w_respKeep    = w_respAcc && (r_dropCount == '0);
  assign w_redirTarget = redirectPc & 32'hFFFF_FFFC;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_respKeep && w_empty && !reset;
`else
  assign w_bypass = 1'b0;
`endif

  assign instrValidF = !w_empty || w_bypass;
  assign instrF      = !w_empty ? r_instrMem[r_rdPtr] : (w_bypass ? imemRespData : C_NOP);
  assign pcF         = !w_empty ? r_pcMem[r_rdPtr]    : (w_bypass ? r_respPc     : r_lastPc);

  assign w_pop     = instrValidF && instrReadyD;
  assign w_fifoPop = w_pop && !w_empty;
  // A bypassed word consumed by ID this cycle never enters the FIFO.
  assign w_push    = w_respKeep && !(w_bypass && instrReadyD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_lastPc      <= 32'h0000_0000;
      r_count       <= '0;
      r_outstanding <= '0;
      r_dropCount   <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
    end else if (redirectValid) begin
      // Redirect wins over push/pop/accept. Every word still owed by imem is
      // stale; one arriving right now is discarded on the spot.
      r_fetchPc     <= w_redirTarget;
      r_respPc      <= w_redirTarget;
      r_count       <= '0;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_outstanding <= r_outstanding - C_CW'(w_respAcc);
      r_dropCount   <= r_outstanding - C_CW'(w_respAcc);
    end else begin
      if (w_accept) begin
        r_fetchPc <= r_fetchPc + 32'd4;
      end
      r_outstanding <= r_outstanding + C_CW'(w_accept) - C_CW'(w_respAcc);
      if (w_respAcc && !w_respKeep) begin
        r_dropCount <= r_dropCount - C_CW'(1);
      end
      if (w_respKeep) begin
        r_respPc <= r_respPc + 32'd4;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + C_AW'(1);
      end
      if (w_fifoPop) begin
        r_rdPtr <= r_rdPtr + C_AW'(1);
      end
      if (w_pop) begin
        r_lastPc <= pcF;
      end
      r_count <= r_count + C_CW'(w_push) - C_CW'(w_fifoPop);
    end
  end

  // Storage needs no reset: entries are only read while r_count says valid.
  always_ff @(posedge clk) begin
    if (!reset && !redirectValid && w_push) begin
      r_instrMem[r_wrPtr] <= imemRespData;
      r_pcMem[r_wrPtr]    <= r_respPc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue. An imem model answers
//            accepted requests in order after a programmable latency; a
//            queue-based reference model predicts DUT outputs each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReqValid;
  logic        imemReqReady = 1'b0;
  logic [31:0] imemReqAddr;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = '0;
  logic        instrValidF;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic        instrReadyD = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirectValid(redirectValid), .redirectPc(redirectPc),
    .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
    .imemRespValid(imemRespValid), .imemRespData(imemRespData),
    .instrValidF(instrValidF), .instrF(instrF), .pcF(pcF), .instrReadyD(instrReadyD)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // per-cycle stimulus knobs
  logic        t_rst = 0, t_redir = 0, t_ready = 0, t_readyD = 0, t_stray = 0, t_ovr = 0;
  logic [31:0] t_rpc = '0, t_ovrData = '0;
  int          lat_min = 1, lat_max = 1;

  // imem model
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t inflight[$];
  int   last_due = 0;
  bit   resp_pop;
  bit   d_acc;
  logic [31:0] d_addr;

  // reference model
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetchPc, m_respPc, m_last;
  int          m_out, m_drop;
  bit          m_respAcc, m_keep, m_byp;
  logic [31:0] r_data;
  logic        e_reqValid, e_valid;
  logic [31:0] e_addr, e_instr, e_pc;

  function automatic logic [31:0] mkword(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Apply knobs at negedge, let combinational outputs settle, predict outputs.
  task automatic drive();
    @(negedge clk);
    reset = t_rst; redirectValid = t_redir; redirectPc = t_rpc;
    imemReqReady = t_ready; instrReadyD = t_readyD;
    resp_pop = 0;
    if (t_stray) begin
      imemRespValid = 1; imemRespData = $urandom;
    end else if (inflight.size() > 0 && inflight[0].due <= cyc) begin
      imemRespValid = 1; resp_pop = 1;
      imemRespData = t_ovr ? t_ovrData : mkword(inflight[0].addr);
    end else begin
      imemRespValid = 0; imemRespData = $urandom;
    end
    #1;
    r_data     = imemRespData;
    e_reqValid = !t_rst && !t_redir && (m_q.size() + m_out < DEPTH);
    e_addr     = m_fetchPc;
    m_respAcc  = imemRespValid && (m_out > 0);
    m_keep     = m_respAcc && (m_drop == 0);
    m_byp      = BYP && m_keep && (m_q.size() == 0) && !t_rst;
    e_valid    = (m_q.size() > 0) || m_byp;
    if (m_q.size() > 0) begin e_instr = m_q[0].instr; e_pc = m_q[0].pc; end
    else if (m_byp)     begin e_instr = r_data;       e_pc = m_respPc; end
    else                begin e_instr = NOP;          e_pc = m_last;   end
    d_acc  = imemReqValid && imemReqReady;
    d_addr = imemReqAddr;
  endtask

  // Clock edge: advance imem model and reference model.
  task automatic tick();
    @(posedge clk);
    if (resp_pop) inflight.delete(0);
    if (d_acc) begin
      int due;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      inflight.push_back('{d_addr, due});
    end
    if (t_rst) begin
      m_fetchPc = RESET_PC; m_respPc = RESET_PC; m_last = 32'h0;
      m_q.delete(); m_out = 0; m_drop = 0;
      inflight.delete(); last_due = 0;
    end else if (t_redir) begin
      m_q.delete();
      m_fetchPc = t_rpc & 32'hFFFF_FFFC; m_respPc = t_rpc & 32'hFFFF_FFFC;
      m_out  = m_out - int'(m_respAcc);
      m_drop = m_out;
    end else begin
      if (e_valid && t_readyD) begin
        m_last = e_pc;
        if (m_q.size() > 0) m_q.delete(0);
      end
      if (e_reqValid && t_ready) begin m_fetchPc += 32'd4; m_out++; end
      if (m_respAcc) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else begin
          if (!(m_byp && t_readyD)) m_q.push_back('{m_respPc, r_data});
          m_respPc += 32'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic knobs(logic rst, logic redir, logic [31:0] rpc, logic rdy, logic rdyD);
    t_rst = rst; t_redir = redir; t_rpc = rpc; t_ready = rdy; t_readyD = rdyD;
    t_stray = 0; t_ovr = 0;
  endtask

  task automatic do_reset();
    knobs(1, 0, 0, 0, 0);
    drive(); tick(); drive(); tick();
    knobs(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    knobs(1, 0, 0, 1, 1);
    drive(); tick();
    for (int i = 0; i < 2; i++) begin
      drive();
      checks++;
      if (imemReqValid !== 1'b0 || instrValidF !== 1'b0 || instrF !== NOP || pcF !== 32'h0 ||
          imemReqAddr !== RESET_PC) begin
        errors++;
        $display("FAIL reset reqV=%b valid=%b instr=%h pc=%h addr=%h (required 0 0 %h 0 %h)",
                 imemReqValid, instrValidF, instrF, pcF, imemReqAddr, NOP, RESET_PC);
      end
      tick();
    end
    knobs(0, 0, 0, 0, 0);
  endtask

  task automatic test_stream();
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    knobs(0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL stream cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (instrValidF && instrReadyD) pcs.push_back(pcF);
      tick();
    end
    checks++;
    if (pcs.size() < 12) begin
      errors++;
      $display("FAIL stream_count consumed=%0d required>=12", pcs.size());
    end
    for (int i = 0; i < pcs.size(); i++) begin
      checks++;
      if (pcs[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL stream_order idx=%0d pc=%h required=%h", i, pcs[i], 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    knobs(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL stall cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (d_acc) acc++;
      tick();
    end
    checks++;
    if (acc != DEPTH || imemReqValid !== 1'b0) begin
      errors++;
      $display("FAIL stall_credit accepted=%0d reqV=%b required %0d 0", acc, imemReqValid, DEPTH);
    end
    t_readyD = 1; t_ready = 1;
    for (int i = 0; i < 8; i++) begin
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL drain cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (instrValidF && instrReadyD) pcs.push_back(pcF);
      tick();
    end
    checks++;
    if (pcs.size() < 5 || pcs[0] !== 32'h0 || pcs[3] !== 32'hC || pcs[4] !== 32'h10) begin
      errors++;
      $display("FAIL drain_order consumed=%0d first=%h fourth=%h fifth=%h required>=5 0 c 10",
               pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX, pcs.size() > 3 ? pcs[3] : 32'hX,
               pcs.size() > 4 ? pcs[4] : 32'hX);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       knobs(0, 0, 0, 1, 0);
      else if (i == 5) knobs(0, 1, 32'h0000_0102, 1, 0);
      else             knobs(0, 0, 0, 1, 1);
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL redirect cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (i == 6) begin
        checks++;
        if (instrValidF !== 1'b0 || imemReqValid !== 1'b1 || imemReqAddr !== 32'h0000_0100) begin
          errors++;
          $display("FAIL redirect_target valid=%b reqV=%b addr=%h required 0 1 00000100",
                   instrValidF, imemReqValid, imemReqAddr);
        end
      end
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      drive();
      if (instrValidF && instrReadyD) pcs.push_back(pcF);
      tick();
    end
    checks++;
    if (pcs.size() < 2 || pcs[0] !== 32'h100 || pcs[1] !== 32'h104) begin
      errors++;
      $display("FAIL redirect_stream consumed=%0d first=%h second=%h required>=2 100 104",
               pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX, pcs.size() > 1 ? pcs[1] : 32'hX);
    end
  endtask

  task automatic test_redirect_resp_pop();
    logic [31:0] pcs[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) knobs(0, 1, 32'h0000_0200, 1, 1);
      else        knobs(0, 0, 0, 1, 1);
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL redir_pop cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (i == 3) begin
        checks++;
        if (instrValidF !== 1'b1 || pcF !== 32'h4) begin
          errors++;
          $display("FAIL redir_pop_setup valid=%b pc=%h required 1 00000004", instrValidF, pcF);
        end
      end
      if (i == 4) begin
        checks++;
        if (instrValidF !== 1'b0 || imemReqAddr !== 32'h0000_0200) begin
          errors++;
          $display("FAIL redir_pop_after valid=%b addr=%h required 0 00000200", instrValidF, imemReqAddr);
        end
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive();
      if (instrValidF && instrReadyD) pcs.push_back(pcF);
      tick();
    end
    checks++;
    if (pcs.size() < 1 || pcs[0] !== 32'h200) begin
      errors++;
      $display("FAIL redir_pop_stream consumed=%0d first=%h required>=1 00000200",
               pcs.size(), pcs.size() > 0 ? pcs[0] : 32'hX);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] addrs[$];
    logic [31:0] pcs[$];
    logic [31:0] exp_a[4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    do_reset();
    lat_min = 1; lat_max = 1;
    knobs(0, 1, 32'hFFFF_FFF8, 1, 1);
    drive(); tick();
    knobs(0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL wrap cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (d_acc) addrs.push_back(d_addr);
      if (instrValidF && instrReadyD) pcs.push_back(pcF);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addrs.size() <= i || addrs[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL wrap_addr idx=%0d addr=%h required=%h", i, addrs.size() > i ? addrs[i] : 32'hX, exp_a[i]);
      end
    end
    checks++;
    if (pcs.size() < 3 || pcs[0] !== exp_a[0] || pcs[1] !== exp_a[1] || pcs[2] !== exp_a[2]) begin
      errors++;
      $display("FAIL wrap_pc consumed=%0d first=%h required>=3 %h", pcs.size(),
               pcs.size() > 0 ? pcs[0] : 32'hX, exp_a[0]);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    lat_min = 1; lat_max = 1;
    knobs(0, 0, 0, 1, 1);
    drive(); tick();
    knobs(0, 0, 0, 0, 1);
    t_ovr = 1; t_ovrData = 32'h0010_0093;
    drive();
    checks++;
    if (instrValidF !== BYP || (BYP && (instrF !== 32'h0010_0093 || pcF !== 32'h0))) begin
      errors++;
      $display("FAIL bypass_same valid=%b instr=%h pc=%h required valid=%b instr=00100093 pc=0",
               instrValidF, instrF, pcF, BYP);
    end
    tick();
    t_ovr = 0;
    drive();
    checks++;
    if (instrValidF !== !BYP || (!BYP && (instrF !== 32'h0010_0093 || pcF !== 32'h0))) begin
      errors++;
      $display("FAIL bypass_next valid=%b instr=%h pc=%h required valid=%b instr=00100093 pc=0",
               instrValidF, instrF, pcF, !BYP);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    do_reset();
    lat_min = 1; lat_max = 2;
    knobs(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin drive(); tick(); end
    knobs(1, 0, 0, 1, 1);
    drive(); tick();
    knobs(0, 0, 0, 0, 1);
    t_stray = 1;
    drive();
    checks++;
    if (instrValidF !== 1'b0 || imemReqValid !== 1'b1 || imemReqAddr !== RESET_PC) begin
      errors++;
      $display("FAIL midreset valid=%b reqV=%b addr=%h required 0 1 %h", instrValidF, imemReqValid, imemReqAddr, RESET_PC);
    end
    tick();
    t_stray = 0;
    drive();
    checks++;
    if (instrValidF !== 1'b0 || imemReqAddr !== RESET_PC) begin
      errors++;
      $display("FAIL stray_resp valid=%b addr=%h required 0 %h", instrValidF, imemReqAddr, RESET_PC);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      knobs(($urandom % 500) == 0, ($urandom % 25) == 0,
            ($urandom % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom,
            ($urandom % 4) != 0, ($urandom % 3) != 0);
      drive();
      checks++;
      if (imemReqValid !== e_reqValid || imemReqAddr !== e_addr || instrValidF !== e_valid ||
          (e_valid && (instrF !== e_instr || pcF !== e_pc))) begin
        errors++;
        $display("FAIL random cyc=%0d reqV=%b/%b addr=%h/%h valid=%b/%b instr=%h/%h pc=%h/%h (got/exp)",
                 cyc, imemReqValid, e_reqValid, imemReqAddr, e_addr, instrValidF, e_valid, instrF, e_instr, pcF, e_pc);
      end
      if (instrValidF && t_readyD && !t_redir && !t_rst) begin
        checks++;
        if (instrF !== mkword(pcF)) begin
          errors++;
          $display("FAIL random_word cyc=%0d pc=%h instr=%h required=%h", cyc, pcF, instrF, mkword(pcF));
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_resp_pop();
    test_wrap();
    test_bypass();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
